// File: rtl/acc_drain_pkg.sv
// acc_drain_pkg: mode encodings, default widths and saturation bounds shared by acc_drain
package acc_drain_pkg;
    localparam logic [1:0] MODE_INT8     = 2'd0;
    localparam logic [1:0] MODE_INT4     = 2'd1;
    localparam logic [1:0] MODE_INT4_VSQ = 2'd2;
    localparam int DEF_LANES = 16;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_OUT_W = 8;
    localparam int INT8_MAX  = 127;
    localparam int INT8_MIN  = -128;
    localparam int INT4_MAX  = 7;
    localparam int INT4_MIN  = -8;
endpackage

// File: rtl/acc_drain_requant_lane.sv
// requant_lane: rounding arithmetic right-shift and saturation of one accumulator lane
module requant_lane
    import acc_drain_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W
)(
    input  logic [ACC_W-1:0] x,
    input  logic [4:0]       shift,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] y
);
    logic signed [ACC_W:0] ext, half, sum, r, hi, lo;
    logic int4;
    // one extra bit of headroom so adding the rounding half can never wrap
    always_comb begin
        int4 = mode == MODE_INT4 || mode == MODE_INT4_VSQ;
        ext  = $signed({x[ACC_W-1], x});
        half = shift == 5'd0 ? '0 : (ACC_W+1)'(1) << (shift - 5'd1);
        sum  = ext + half;
        r    = sum >>> shift;
        hi   = int4 ? (ACC_W+1)'(INT4_MAX) : (ACC_W+1)'(INT8_MAX);
        lo   = int4 ? (ACC_W+1)'(INT4_MIN) : (ACC_W+1)'(INT8_MIN);
        y    = r > hi ? hi[OUT_W-1:0] : r < lo ? lo[OUT_W-1:0] : r[OUT_W-1:0];
    end
endmodule

// File: rtl/acc_drain.sv
// acc_drain: double-buffered capture, requantization and valid/ready streaming of accumulator tiles
module acc_drain
    import acc_drain_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int ROWS  = 16,
    parameter int TC    = 32,
    parameter int TR    = 32
)(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [1:0]             i_mode,
    input  logic [4:0]             i_shift,
    input  logic                   i_in_valid,
    input  logic [LANES*ACC_W-1:0] i_in_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [LANES*OUT_W-1:0] o_out_data,
    output logic [13:0]            o_out_addr,
    output logic                   o_out_last,
    output logic                   o_mtrx_last,
    output logic                   o_busy,
    output logic                   o_overflow
);
    logic [LANES*OUT_W-1:0] mem [2][ROWS];
    logic [LANES*OUT_W-1:0] q;
    logic [1:0] full, lat_mode, mode;
    logic [4:0] lat_shift, shift, tile_col, tile_row;
    logic [3:0] wr_row, rd_row;
    logic wr_bank, rd_bank, wr_en, rd_en, wr_end, rd_end, col_end, row_end;

    // the first row of a tile requantizes with the live mode/shift it is latching
    assign mode    = wr_row == '0 ? i_mode : lat_mode;
    assign shift   = wr_row == '0 ? i_shift : lat_shift;
    assign wr_en   = i_in_valid && !full[wr_bank];
    assign rd_en   = full[rd_bank] && (!o_out_valid || i_out_ready);
    assign wr_end  = wr_row == 4'(ROWS-1);
    assign rd_end  = rd_row == 4'(ROWS-1);
    assign col_end = tile_col == 5'(TC-1);
    assign row_end = tile_row == 5'(TR-1);
    assign o_busy  = |full || o_out_valid;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        requant_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
            .x    (i_in_data[g*ACC_W +: ACC_W]),
            .shift(shift),
            .mode (mode),
            .y    (q[g*OUT_W +: OUT_W])
        );
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_bank][wr_row] <= q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full        <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_row      <= '0;
            rd_row      <= '0;
            tile_col    <= '0;
            tile_row    <= '0;
            lat_mode    <= MODE_INT8;
            lat_shift   <= '0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_addr  <= '0;
            o_out_last  <= 1'b0;
            o_mtrx_last <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_row == '0) begin
                    lat_mode  <= i_mode;
                    lat_shift <= i_shift;
                end
                wr_row <= wr_end ? '0 : wr_row + 4'd1;
                if (wr_end) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end else if (i_in_valid) begin
                o_overflow <= 1'b1;
            end
            if (rd_en) begin
                o_out_valid <= 1'b1;
                o_out_data  <= mem[rd_bank][rd_row];
                o_out_addr  <= {tile_row, tile_col, rd_row};
                o_out_last  <= rd_end;
                o_mtrx_last <= rd_end && col_end && row_end;
                rd_row      <= rd_end ? '0 : rd_row + 4'd1;
                if (rd_end) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    tile_col      <= col_end ? '0 : tile_col + 5'd1;
                    if (col_end) tile_row <= row_end ? '0 : tile_row + 5'd1;
                end
            end else if (i_out_ready) begin
                o_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: directed self-checking bench for acc_drain
module tb_acc_drain;
    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [1:0]   i_mode = '0;
    logic [4:0]   i_shift = '0;
    logic         i_in_valid = 1'b0;
    logic [383:0] i_in_data = '0;
    logic         o_out_valid;
    logic         i_out_ready = 1'b1;
    logic [127:0] o_out_data;
    logic [13:0]  o_out_addr;
    logic         o_out_last, o_mtrx_last, o_busy, o_overflow;

    int n_chk = 0, n_pass = 0, n_rows = 0, n_mtrx = 0, waits;
    logic [13:0]  mtrx_addr = '0;
    logic [4:0]   exp_tc = '0, exp_tr = '0;
    logic [127:0] exp_data [16];

    acc_drain dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_shift(i_shift),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_addr(o_out_addr),
        .o_out_last(o_out_last), .o_mtrx_last(o_mtrx_last), .o_busy(o_busy),
        .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        if (o_out_valid && i_out_ready) begin
            n_rows++;
            if (o_mtrx_last) begin
                n_mtrx++;
                mtrx_addr = o_out_addr;
            end
        end
    endtask

    function automatic logic [383:0] row24(input logic [23:0] a, b, c, d, e);
        row24 = {16{e}};
        row24[23:0] = a; row24[47:24] = b; row24[71:48] = c; row24[95:72] = d;
    endfunction

    function automatic logic [127:0] row8(input logic [7:0] a, b, c, d, e);
        row8 = {16{e}};
        row8[7:0] = a; row8[15:8] = b; row8[23:16] = c; row8[31:24] = d;
    endfunction

    task automatic write_tile(input logic [1:0] m0, input logic [4:0] s0, input logic [383:0] d0,
                              input logic [1:0] m1, input logic [4:0] s1, input logic [383:0] d1);
        for (int r = 0; r < 16; r++) begin
            i_in_valid = 1'b1;
            i_mode     = r == 0 ? m0 : m1;
            i_shift    = r == 0 ? s0 : s1;
            i_in_data  = r == 0 ? d0 : d1;
            step();
        end
        i_in_valid = 1'b0;
    endtask

    task automatic write_seq(input logic [23:0] base);
        for (int r = 0; r < 16; r++) begin
            i_in_valid = 1'b1;
            i_mode     = 2'd0;
            i_shift    = 5'd0;
            i_in_data  = {16{base + 24'(r)}};
            step();
        end
        i_in_valid = 1'b0;
    endtask

    task automatic exp_fill(input logic [127:0] d0, input logic [127:0] d1);
        for (int r = 0; r < 16; r++) exp_data[r] = r == 0 ? d0 : d1;
    endtask

    task automatic exp_seq(input logic [7:0] base);
        for (int r = 0; r < 16; r++) exp_data[r] = {16{8'(base + 8'(r))}};
    endtask

    task automatic drain(input string tag, input int stall_at, input int stop_at, output int w);
        w = 0;
        while (!o_out_valid && w < 40) begin
            step();
            w++;
        end
        chk({tag, " valid"}, o_out_valid, 1'b1);
        for (int r = 0; r < 16; r++) begin
            chk($sformatf("%s addr r%0d", tag, r), o_out_addr, {exp_tr, exp_tc, 4'(r)});
            chk($sformatf("%s data r%0d", tag, r), o_out_data, exp_data[r]);
            chk($sformatf("%s last r%0d", tag, r), o_out_last, r == 15);
            chk($sformatf("%s mtrx r%0d", tag, r), o_mtrx_last,
                r == 15 && exp_tr == 5'd31 && exp_tc == 5'd31);
            if (r == stop_at) return;
            if (r == stall_at) begin
                i_out_ready = 1'b0;
                repeat (10) step();
                chk({tag, " stall valid"}, o_out_valid, 1'b1);
                chk({tag, " stall addr"}, o_out_addr, {exp_tr, exp_tc, 4'(r)});
                chk({tag, " stall data"}, o_out_data, exp_data[r]);
                chk({tag, " stall busy"}, o_busy, 1'b1);
                i_out_ready = 1'b1;
            end
            step();
        end
        exp_tc = exp_tc + 5'd1;
        if (exp_tc == 5'd0) exp_tr = exp_tr + 5'd1;
    endtask

    initial begin
        step();
        step();
        chk("rst valid", o_out_valid, 1'b0);
        chk("rst data", o_out_data, '0);
        chk("rst addr", o_out_addr, '0);
        chk("rst last", o_out_last, 1'b0);
        chk("rst mtrx", o_mtrx_last, 1'b0);
        chk("rst busy", o_busy, 1'b0);
        chk("rst ovf", o_overflow, 1'b0);
        i_rst = 1'b0;

        // basic INT8 tile, shift 4: (291+8)>>4 = 18
        write_tile(2'd0, 5'd4, {16{24'h000123}}, 2'd0, 5'd4, {16{24'h000123}});
        chk("t1 latency valid", o_out_valid, 1'b0);
        chk("t1 busy", o_busy, 1'b1);
        exp_fill({16{8'h12}}, {16{8'h12}});
        drain("t1", -1, -1, waits);
        chk("t1 first valid delay", 32'(waits), 32'd1);
        step();
        chk("t1 idle valid", o_out_valid, 1'b0);
        chk("t1 idle busy", o_busy, 1'b0);

        // saturation; later rows carry a different mode/shift that must be ignored
        write_tile(2'd0, 5'd0, row24(24'h7FFFFF, 24'h800000, 24'd5, 24'hFFFF38, 24'd0),
                   2'd1, 5'd3, row24(24'h7FFFFF, 24'd100, 24'd100, 24'd100, 24'd100));
        exp_fill(row8(8'h7F, 8'h80, 8'h05, 8'h80, 8'h00), row8(8'h7F, 8'h64, 8'h64, 8'h64, 8'h64));
        drain("t2 int8", -1, -1, waits);
        write_tile(2'd1, 5'd2, row24(24'd100, 24'hFFFF9C, 24'hFFFFFA, 24'd6, 24'd0),
                   2'd0, 5'd0, row24(24'd100, 24'hFFFF9C, 24'hFFFFFA, 24'd6, 24'd0));
        exp_fill(row8(8'h07, 8'hF8, 8'hFF, 8'h02, 8'h00), row8(8'h07, 8'hF8, 8'hFF, 8'h02, 8'h00));
        drain("t2 int4", -1, -1, waits);
        write_tile(2'd2, 5'd0, {16{24'd9}}, 2'd2, 5'd0, {16{24'd9}});
        exp_fill({16{8'h07}}, {16{8'h07}});
        drain("t2 vsq", -1, -1, waits);
        write_tile(2'd3, 5'd0, {16{24'd9}}, 2'd3, 5'd0, {16{24'd9}});
        exp_fill({16{8'h09}}, {16{8'h09}});
        drain("t2 mode3", -1, -1, waits);
        write_tile(2'd0, 5'd23, row24(24'h7FFFFF, 24'h800000, 24'd0, 24'd0, 24'd0),
                   2'd0, 5'd23, row24(24'h7FFFFF, 24'h800000, 24'd0, 24'd0, 24'd0));
        exp_fill(row8(8'h01, 8'hFF, 8'h00, 8'h00, 8'h00), row8(8'h01, 8'hFF, 8'h00, 8'h00, 8'h00));
        drain("t2 shift23", -1, -1, waits);

        // back-pressure held for 10 cycles on row 5
        write_seq(24'h01);
        exp_seq(8'h01);
        drain("t3", 5, -1, waits);

        // both banks full, third row dropped
        i_out_ready = 1'b0;
        write_seq(24'h21);
        write_seq(24'h41);
        chk("t4 busy full", o_busy, 1'b1);
        chk("t4 no ovf yet", o_overflow, 1'b0);
        i_in_valid = 1'b1;
        i_in_data  = {16{24'h000055}};
        step();
        i_in_valid = 1'b0;
        chk("t4 ovf set", o_overflow, 1'b1);
        i_out_ready = 1'b1;
        exp_seq(8'h21);
        drain("t4 a", -1, -1, waits);
        exp_seq(8'h41);
        drain("t4 b", -1, -1, waits);
        chk("t4 b no bubble", 32'(waits), 32'd0);
        step();
        chk("t4 drained valid", o_out_valid, 1'b0);
        chk("t4 ovf sticky", o_overflow, 1'b1);

        // reset while draining row 7
        write_tile(2'd0, 5'd0, {16{24'd3}}, 2'd0, 5'd0, {16{24'd3}});
        exp_fill({16{8'h03}}, {16{8'h03}});
        drain("t6 pre", -1, 7, waits);
        i_rst = 1'b1;
        #1;
        chk("t6 rst valid", o_out_valid, 1'b0);
        chk("t6 rst data", o_out_data, '0);
        chk("t6 rst addr", o_out_addr, '0);
        chk("t6 rst busy", o_busy, 1'b0);
        chk("t6 rst ovf", o_overflow, 1'b0);
        step();
        i_rst = 1'b0;
        repeat (5) step();
        chk("t6 no partial", o_out_valid, 1'b0);
        exp_tc = '0;
        exp_tr = '0;
        write_tile(2'd0, 5'd0, {16{24'd7}}, 2'd0, 5'd0, {16{24'd7}});
        exp_fill({16{8'h07}}, {16{8'h07}});
        drain("t6 fresh", -1, -1, waits);

        // remaining 1023 tiles of the matrix
        n_rows = 0;
        n_mtrx = 0;
        for (int k = 0; k < 1023; k++) begin
            write_tile(2'd0, 5'd0, {16{24'd1}}, 2'd0, 5'd0, {16{24'd1}});
            step();
            step();
        end
        repeat (40) step();
        chk("t5 rows", 32'(n_rows), 32'd16368);
        chk("t5 mtrx count", 32'(n_mtrx), 32'd1);
        chk("t5 mtrx addr", mtrx_addr, 14'h3FFF);
        chk("t5 no ovf", o_overflow, 1'b0);
        exp_tc = '0;
        exp_tr = '0;
        write_tile(2'd0, 5'd0, {16{24'd2}}, 2'd0, 5'd0, {16{24'd2}});
        exp_fill({16{8'h02}}, {16{8'h02}});
        drain("t5 wrap", -1, -1, waits);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/acc_drain.md
Name: acc_drain

Overview:
- Downstream of the matmul controller/MAC array.
- Captures the 16 finished accumulator rows of each output tile (16 lanes × 24-bit psums). Requantizes each lane to 8-bit with a rounding right-shift and saturation, then streams the rows out over a valid/ready interface to the output writeback.
- Double-buffered, so the controller can start the next tile while the previous one drains. The controller has no back-pressure, so a third tile arriving while both banks are full is dropped and flagged.

Parameters:
- LANES, 16, MAC lanes per row.
- ACC_W, 24, accumulator width per lane.
- OUT_W, 8, output width per lane.
- ROWS, 16, rows per tile (accumulator depth).
- TC, 32, tile columns per matrix (N/16).
- TR, 32, tile rows per matrix.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_mode  in  2  0 INT8, 1 INT4, 2 INT4_VSQ; sampled on first row of each tile.
- i_shift  in  5  requant right-shift amount, 0..23; sampled with i_mode.
- i_in_valid  in  1  one accumulator row present this cycle.
- i_in_data  in  LANES*ACC_W  row data; lane g at [g*ACC_W +: ACC_W], two's complement.
- o_out_valid  out  1  output row valid.
- i_out_ready  in  1  consumer accepts row.
- o_out_data  out  LANES*OUT_W  requantized row; lane g at [g*OUT_W +: OUT_W].
- o_out_addr  out  14  {tile_row[4:0], tile_col[4:0], row_in_tile[3:0]}.
- o_out_last  out  1  last row of tile.
- o_mtrx_last  out  1  last row of last tile (tile_row=TR-1, tile_col=TC-1, row=15).
- o_busy  out  1  either bank full or output valid.
- o_overflow  out  1  sticky: a row was dropped.

Behaviour:
- Reset (async, i_rst=1): all outputs 0; bank-full flags 0; write/read bank pointers 0; row counters 0; tile counters 0; o_overflow 0. Reset mid-tile discards all buffered data; no partial output after release.
- Requant per lane, applied on write:
  - r = (x + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, computed in 25-bit signed so +half never overflows.
  - Saturate: INT8 to [-128,127]; INT4/INT4_VSQ to [-8,7], sign-extended to 8 bits.
  - Mode 3 is treated as INT8.
- Write side:
  - On i_in_valid, if the write bank is not full: store the row at wr_row, then increment wr_row.
  - When wr_row==15 is written: set that bank's full flag, toggle the write bank, wr_row←0.
  - If the write bank is full: the row is dropped, o_overflow←1 (sticky), wr_row unchanged.
  - Mode and shift are latched when wr_row==0 is written and held for the whole tile.
- Read side:
  - Output register stage. Load when the read bank is full and (!o_out_valid or i_out_ready).
  - Latency: bank full on cycle t, then o_out_valid=1 on t+1.
  - A row transfers on o_out_valid && i_out_ready; o_out_data/addr hold stable while valid && !ready.
  - After row 15 is loaded: clear that bank's full flag, toggle the read bank, advance tile_col; on wrap past TC-1, advance tile_row; on wrap past TR-1, wrap to 0.
  - Back-to-back banks stream with no bubble when i_out_ready stays 1.
- Simultaneous write-completion and read-free of different banks in one cycle: both take effect. A bank freed this cycle may accept a write next cycle, not the same cycle.
- o_out_last=1 with row_in_tile==15. o_mtrx_last additionally requires tile_row==TR-1 and tile_col==TC-1.

Decomposition:
- Shared package: mode encodings (MODE_INT8=0, MODE_INT4=1, MODE_INT4_VSQ=2), LANES/ACC_W/OUT_W defaults, INT8/INT4 saturation bounds.
- One sub-module, requant_lane: combinational round/shift/saturate for one lane, instantiated LANES times in a generate loop.
- Bank storage is plain registers inside acc_drain.

Test Plan:
1. INT8, shift=4; 16 rows, all lanes 0x000123 (291) → r = (291+8)>>4 = 18 = 0x12 per lane; 16 outputs addr 0..15, o_out_last on row 15, first valid 1 cycle after 16th write.
2. Saturation: INT8 shift=0, lanes 0x7FFFFF / 0x800000 → 0x7F / 0x80; INT4 shift=2, x=100 → 7 (0x07), x=-100 → -8 (0xF8); x=-6 shift=2 → (-6+2)>>>2 = -1 (0xFF).
3. Back-pressure: i_out_ready=0 for 10 cycles mid-tile → data/addr stable, no row lost; release gives contiguous order.
4. Double buffering: two tiles streamed back-to-back with ready=0 → both banks full, o_busy=1; a third row → o_overflow=1, row dropped; after drain, tile_col advances 0→1→2.
5. Full matrix: 1024 tiles with ready=1 → o_mtrx_last exactly once, at addr {31,31,15}; next tile's addr wraps to 0.
6. Reset asserted mid-drain (row 7) → all outputs 0 immediately; after release, a fresh tile outputs addr 0..15 cleanly.
